// File: rtl/jtpopeye_vtimer.sv
// Parametrised video timing generator: H/V pixel counters, blanking, sync,
// DMA window, frame pulse, odd/even flag and flip-aware counter outputs.
module jtpopeye_vtimer #(
    parameter int unsigned HW       = 9,
    parameter int unsigned VW       = 9,
    parameter int unsigned HTOTAL   = 384,
    parameter int unsigned VTOTAL   = 264,
    parameter int unsigned HB_START = 256,
    parameter int unsigned HB_END   = 0,
    parameter int unsigned HS_START = 300,
    parameter int unsigned HS_END   = 332,
    parameter int unsigned VB_START = 240,
    parameter int unsigned VB_END   = 8,
    parameter int unsigned VS_START = 248,
    parameter int unsigned VS_END   = 251,
    parameter int unsigned DMA_LEN  = 32
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          pxl_cen,
    input  logic          RV_n,
    output logic [HW-1:0] H,
    output logic [VW-1:0] V,
    output logic [HW-1:0] HF,
    output logic [VW-1:0] VF,
    output logic          HB,
    output logic          VB,
    output logic          HS,
    output logic          VS,
    output logic          HBD_n,
    output logic          frame_start,
    output logic          odd
);

    localparam int unsigned DW = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
    localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
    localparam logic [DW-1:0] DMA_LOAD = DW'(DMA_LEN - 1);
    localparam bit HB_ON  = (HB_START != HB_END);
    localparam bit HS_ON  = (HS_START != HS_END);
    localparam bit VB_ON  = (VB_START != VB_END);
    localparam bit VS_ON  = (VS_START != VS_END);
    localparam bit DMA_ON = (DMA_LEN != 0);

    // Parameter sanity checks at elaboration
    if (HTOTAL > 2**HW) begin : g_bad_htotal
        $error("jtpopeye_vtimer: HTOTAL does not fit in HW bits");
    end
    if (VTOTAL > 2**VW) begin : g_bad_vtotal
        $error("jtpopeye_vtimer: VTOTAL does not fit in VW bits");
    end
    if (HB_START >= HTOTAL || HB_END >= HTOTAL || HS_START >= HTOTAL || HS_END >= HTOTAL)
    begin : g_bad_hpos
        $error("jtpopeye_vtimer: horizontal position outside 0..HTOTAL-1");
    end
    if (VB_START >= VTOTAL || VB_END >= VTOTAL || VS_START >= VTOTAL || VS_END >= VTOTAL)
    begin : g_bad_vpos
        $error("jtpopeye_vtimer: vertical position outside 0..VTOTAL-1");
    end

    logic [HW-1:0] h_nx;
    logic [VW-1:0] v_nx;
    logic [DW-1:0] dma_cnt, dma_nx;
    logic          hb_nx, vb_nx, hs_nx, vs_nx, hbd_nx, fs_nx, odd_nx;
    logic          h_last, v_last;

    assign h_last = (H == H_LAST);
    assign v_last = (V == V_LAST);

    // Flip only affects the counter view handed to the layers
    assign HF = RV_n ? H : ~H;
    assign VF = RV_n ? V : ~V;

    // Next-state: flags are decided on the pre-increment counter values
    always_comb begin
        h_nx   = H;
        v_nx   = V;
        hb_nx  = HB;
        vb_nx  = VB;
        hs_nx  = HS;
        vs_nx  = VS;
        hbd_nx = HBD_n;
        dma_nx = dma_cnt;
        odd_nx = odd;
        fs_nx  = 1'b0;
        if (pxl_cen) begin
            h_nx = h_last ? '0 : H + HW'(1);
            if (h_last) begin
                v_nx = v_last ? '0 : V + VW'(1);
                if (v_last) begin
                    odd_nx = ~odd;
                    fs_nx  = 1'b1;
                end
            end
            if (HB_ON) begin
                if (H == HW'(HB_START))    hb_nx = 1'b1;
                else if (H == HW'(HB_END)) hb_nx = 1'b0;
            end
            if (HS_ON) begin
                if (H == HW'(HS_START))    hs_nx = 1'b1;
                else if (H == HW'(HS_END)) hs_nx = 1'b0;
            end
            if (h_last && VB_ON) begin
                if (V == VW'(VB_START))    vb_nx = 1'b1;
                else if (V == VW'(VB_END)) vb_nx = 1'b0;
            end
            if (h_last && VS_ON) begin
                if (V == VW'(VS_START))    vs_nx = 1'b1;
                else if (V == VW'(VS_END)) vs_nx = 1'b0;
            end
            // DMA slot opens with HB and closes on length expiry or HB end
            if (DMA_ON && HB_ON) begin
                if (H == HW'(HB_START)) begin
                    hbd_nx = 1'b0;
                    dma_nx = DMA_LOAD;
                end else if (!HBD_n) begin
                    if (H == HW'(HB_END) || dma_cnt == '0) hbd_nx = 1'b1;
                    else                                   dma_nx = dma_cnt - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H           <= '0;
            V           <= '0;
            HB          <= 1'b1;
            VB          <= 1'b1;
            HS          <= 1'b0;
            VS          <= 1'b0;
            HBD_n       <= 1'b1;
            dma_cnt     <= '0;
            frame_start <= 1'b0;
            odd         <= 1'b0;
        end else begin
            H           <= h_nx;
            V           <= v_nx;
            HB          <= hb_nx;
            VB          <= vb_nx;
            HS          <= hs_nx;
            VS          <= vs_nx;
            HBD_n       <= hbd_nx;
            dma_cnt     <= dma_nx;
            frame_start <= fs_nx;
            odd         <= odd_nx;
        end
    end

endmodule
